// File: rtl/aes_pkg.sv
// Shared AES-128 constants, state encoding and GF(2^8) helpers.
package aes_pkg;

    localparam int         NR        = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] GF_POLY   = 8'h1b;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
    endfunction

    // General GF(2^8) multiply as shift-and-add over xtime.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = xtime(aa);
        end
        return acc;
    endfunction

    // S-box computed as multiplicative inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] p;
        inv = 8'h01;
        p   = x;
        for (int i = 1; i < 8; i++) begin
            p   = gf_mul(p, p);
            inv = gf_mul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Byte number of row r in column c (column-major state layout).
    function automatic int byte_idx(input int c, input int r);
        return 4 * c + r;
    endfunction

endpackage

// File: rtl/SubBytes.sv
// SubBytes stage: sixteen parallel S-boxes over the 128-bit state.
module SubBytes (
    input  logic [127:0] in_state,
    output logic [127:0] out_state
);

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_sbox
            sbox u_sbox (
                .in_byte (in_state[127-8*gi -: 8]),
                .out_byte(out_state[127-8*gi -: 8])
            );
        end
    endgenerate

endmodule

// File: rtl/next_round_key.sv
// One step of AES-128 key expansion: (roundKey, rcon) -> next round key.
module next_round_key (
    input  logic [127:0] round_key,
    input  logic [7:0]   rcon,
    output logic [127:0] next_key
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_w3;
    logic [31:0] sub_w3;
    logic [31:0] w4, w5, w6, w7;

    assign {w0, w1, w2, w3} = round_key;
    assign rot_w3 = {w3[23:0], w3[31:24]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_subword
            sbox u_sbox (
                .in_byte (rot_w3[31-8*gi -: 8]),
                .out_byte(sub_w3[31-8*gi -: 8])
            );
        end
    endgenerate

    assign w4 = w0 ^ sub_w3 ^ {rcon, 24'h0};
    assign w5 = w1 ^ w4;
    assign w6 = w2 ^ w5;
    assign w7 = w3 ^ w6;
    assign next_key = {w4, w5, w6, w7};

endmodule

// File: rtl/sbox.sv
// Single AES forward S-box, purely combinational.
module sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    assign out_byte = sbox_calc(in_byte);

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES-128 encryptor: one round per clock, key expanded on the fly.
module aes_cipher_iter
    import aes_pkg::*;
#(
    parameter int NR = aes_pkg::NR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] plainText,
    input  logic [127:0] key,
    output logic         busy,
    output logic         done,
    output logic [127:0] cipherText
);

    state_e       fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] round_key_q, round_key_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   round_q, round_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [127:0] ct_q, ct_d;

    logic [127:0] sub_state;
    logic [127:0] shifted;
    logic [127:0] mixed;
    logic [127:0] round_out;
    logic [127:0] next_key;
    logic         last_round;

    SubBytes u_sub_bytes (
        .in_state (state_q),
        .out_state(sub_state)
    );

    next_round_key u_next_round_key (
        .round_key(round_key_q),
        .rcon     (rcon_q),
        .next_key (next_key)
    );

    // ShiftRows: byte (c,r) takes the byte from column (c+r) mod 4 of the same row.
    genvar gi, gj;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_shift_col
            for (gj = 0; gj < 4; gj++) begin : g_shift_row
                localparam int DST = byte_idx(gi, gj);
                localparam int SRC = byte_idx((gi + gj) % 4, gj);
                assign shifted[127-8*DST -: 8] = sub_state[127-8*SRC -: 8];
            end
        end
    endgenerate

    // MixColumns on each column using only xtime and XOR.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_mix
            localparam int MSB = 127 - 32 * gi;
            logic [7:0] a0, a1, a2, a3;
            assign a0 = shifted[MSB    -: 8];
            assign a1 = shifted[MSB-8  -: 8];
            assign a2 = shifted[MSB-16 -: 8];
            assign a3 = shifted[MSB-24 -: 8];
            assign mixed[MSB    -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            assign mixed[MSB-8  -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            assign mixed[MSB-16 -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            assign mixed[MSB-24 -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
    endgenerate

    // The final round skips MixColumns.
    assign last_round = (round_q == 4'(NR));
    assign round_out  = last_round ? shifted : mixed;

    // Next-state logic: accept in IDLE, advance one round per cycle in RUN.
    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        round_key_d = round_key_q;
        rcon_d      = rcon_q;
        round_d     = round_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        ct_d        = ct_q;
        case (fsm_q)
            IDLE: begin
                if (start) begin
                    state_d     = plainText ^ key;
                    round_key_d = key;
                    rcon_d      = RCON_INIT;
                    round_d     = 4'd1;
                    busy_d      = 1'b1;
                    fsm_d       = RUN;
                end
            end
            RUN: begin
                state_d     = round_out ^ next_key;
                round_key_d = next_key;
                rcon_d      = xtime(rcon_q);
                round_d     = round_q + 4'd1;
                if (last_round) begin
                    ct_d   = round_out ^ next_key;
                    done_d = 1'b1;
                    busy_d = 1'b0;
                    fsm_d  = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // State registers; reset clears everything and drops any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            round_key_q <= '0;
            rcon_q      <= '0;
            round_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ct_q        <= '0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            round_key_q <= round_key_d;
            rcon_q      <= rcon_d;
            round_q     <= round_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ct_q        <= ct_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign cipherText = ct_q;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Directed bench for aes_cipher_iter using FIPS-197 known-answer vectors.
module tb_aes_cipher_iter;

    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] RK_Z  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] plain_text;
    logic [127:0] key_in;
    logic         busy;
    logic         done;
    logic [127:0] cipher_text;

    int n_tests = 0;
    int n_fail  = 0;

    aes_cipher_iter #(.NR(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .plainText (plain_text),
        .key       (key_in),
        .busy      (busy),
        .done      (done),
        .cipherText(cipher_text)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts one operation and follows it for a bounded number of cycles.
    task automatic run_op(input string tag, input logic [127:0] p, input logic [127:0] k,
                          input logic [127:0] exp);
        int done_cyc  = 0;
        int busy_cnt  = 0;
        int done_cnt  = 0;
        plain_text = p;
        key_in     = k;
        start      = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c == 1) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
        end
        chk({tag, " done_cycle"}, 128'(done_cyc), 128'd11);
        chk({tag, " busy_cycles"}, 128'(busy_cnt), 128'd10);
        chk({tag, " done_count"}, 128'(done_cnt), 128'd1);
        chk({tag, " ct"}, cipher_text, exp);
        $display("[TB] %s: pt=%h key=%h ct=%h done_cycle=%0d", tag, p, k, cipher_text, done_cyc);
    endtask

    initial begin
        int done_cnt;
        int done_cyc;

        rst        = 1'b1;
        start      = 1'b0;
        plain_text = '0;
        key_in     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 128'(busy), 128'd0);
        chk("reset done", 128'(done), 128'd0);
        chk("reset ct", cipher_text, 128'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Known-answer vectors.
        run_op("appB", PT_B, KEY_B, CT_B);
        run_op("appC1", PT_C, KEY_C, CT_C);
        run_op("zero", 128'h0, 128'h0, CT_Z);
        chk("zero last round key", dut.round_key_q, RK_Z);

        // start pulses and operand changes during RUN must be ignored.
        plain_text = PT_B;
        key_in     = KEY_B;
        start      = 1'b1;
        done_cnt   = 0;
        done_cyc   = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            start = (c == 3 || c == 7);
            if (c == 3) begin
                plain_text = PT_C;
                key_in     = KEY_C;
            end
            if (c == 7) plain_text = 128'hdeadbeef_01234567_89abcdef_cafef00d;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
        end
        start = 1'b0;
        chk("ignore start done_count", 128'(done_cnt), 128'd1);
        chk("ignore start done_cycle", 128'(done_cyc), 128'd11);
        chk("ignore start ct", cipher_text, CT_B);
        $display("[TB] ignore-start: ct=%h dones=%0d", cipher_text, done_cnt);

        // start held high: second op accepted in the cycle done is high.
        plain_text = PT_B;
        key_in     = KEY_B;
        start      = 1'b1;
        done_cnt   = 0;
        for (int c = 1; c <= 26; c++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
            if (c == 11) begin
                chk("b2b first done", 128'(done), 128'd1);
                chk("b2b first ct", cipher_text, CT_B);
                plain_text = PT_C;
                key_in     = KEY_C;
            end
            if (c == 12) chk("b2b busy after accept", 128'(busy), 128'd1);
            if (c == 15) chk("b2b ct held", cipher_text, CT_B);
            if (c == 22) begin
                chk("b2b second done", 128'(done), 128'd1);
                chk("b2b second ct", cipher_text, CT_C);
                start = 1'b0;
            end
        end
        chk("b2b done_count", 128'(done_cnt), 128'd2);
        $display("[TB] back-to-back: ct=%h dones=%0d", cipher_text, done_cnt);

        // Reset in the middle of an operation.
        plain_text = PT_B;
        key_in     = KEY_B;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre-reset busy", 128'(busy), 128'd1);
        rst = 1'b1;
        #1;
        chk("mid reset busy", 128'(busy), 128'd0);
        chk("mid reset done", 128'(done), 128'd0);
        chk("mid reset ct", cipher_text, 128'h0);
        @(posedge clk); #1;
        rst      = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        chk("post reset no done", 128'(done_cnt), 128'd0);
        chk("post reset ct", cipher_text, 128'h0);
        $display("[TB] reset mid-op: busy=%0d ct=%h", busy, cipher_text);
        run_op("appB after reset", PT_B, KEY_B, CT_B);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
